// File: rtl/ms_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ms_slave_arbiter
// Purpose  : Round-robin arbiter sharing one held-notify master channel
//            between two sync-flagged requesters, with xfer/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module ms_slave_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_in,
  input  logic             s_in_sync,
  input  logic [31:0]      s_in2,
  input  logic             s_in2_sync,
  output logic [31:0]      m_out,
  output logic             m_out_notify,
  input  logic             m_out_sync,
  output logic [31:0]      shared_out,
  output logic             grant_src,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [0:0] {
    section_idle = 1'b0,
    section_send = 1'b1
  } sections_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W:0]   C_SUM_MAX = {1'b0, C_CNT_MAX};

  sections_t        r_section;
  logic             r_prio;
  logic [31:0]      r_m_out;
  logic             r_m_out_notify;
  logic [31:0]      r_shared_out;
  logic             r_grant_src;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_any_req;
  logic             w_both_req;
  logic             w_grant_b;
  logic [31:0]      w_grant_data;
  logic [1:0]       w_drop_inc;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_next;

  assign w_any_req    = s_in_sync | s_in2_sync;
  assign w_both_req   = s_in_sync & s_in2_sync;
  // On a tie the favoured source wins; otherwise whichever side asked.
  assign w_grant_b    = w_both_req ? r_prio : s_in2_sync;
  assign w_grant_data = w_grant_b ? s_in2 : s_in;

  always_comb begin
    w_drop_inc = 2'd0;
    if (r_section == section_send)
      w_drop_inc = {1'b0, s_in_sync} + {1'b0, s_in2_sync};
    else if (w_both_req)
      w_drop_inc = 2'd1;
  end

  // One extra bit of headroom so the saturation test sees the true sum.
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {{(CNT_W - 1){1'b0}}, w_drop_inc};
  assign w_drop_next = (w_drop_sum > C_SUM_MAX) ? C_CNT_MAX : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section      <= section_idle;
      r_prio         <= 1'b0;
      r_m_out        <= 32'd0;
      r_m_out_notify <= 1'b0;
      r_shared_out   <= 32'd0;
      r_grant_src    <= 1'b0;
      r_xfer_cnt     <= '0;
      r_drop_cnt     <= '0;
    end else begin
      r_drop_cnt <= w_drop_next;
      case (r_section)
        section_idle: begin
          if (w_any_req) begin
            r_m_out        <= w_grant_data;
            r_m_out_notify <= 1'b1;
            r_grant_src    <= w_grant_b;
            r_prio         <= ~w_grant_b;
            r_section      <= section_send;
          end
        end
        section_send: begin
          if (m_out_sync) begin
            r_m_out_notify <= 1'b0;
            r_shared_out   <= r_m_out;
            r_xfer_cnt     <= r_xfer_cnt + 1'b1;
            r_section      <= section_idle;
          end
        end
      endcase
    end
  end

  assign m_out        = r_m_out;
  assign m_out_notify = r_m_out_notify;
  assign shared_out   = r_shared_out;
  assign grant_src    = r_grant_src;
  assign busy         = (r_section == section_send);
  assign xfer_cnt     = r_xfer_cnt;
  assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire
